// File: rtl/conv_interleave_tx.sv
// Convolutional byte interleaver with a bit-serial output stage.
// Each accepted byte is routed to one of BRANCHES branches by a
// commutator. Branch 0 has no delay. Branch j is a j*UNIT_DEPTH byte
// FIFO. The interleaved byte is then shifted out MSB first on dout_bit.
// All branch FIFOs share one packed storage vector. Each FIFO is a
// region of that vector with its own circular read/write pointer.
// A FIFO is always full, so the slot under its pointer is the oldest entry.
module conv_interleave_tx #(
   parameter int BRANCHES   = 12,
   parameter int UNIT_DEPTH = 17
) (
   input  logic       clk_bit,
   input  logic       rst_n,
   input  logic [7:0] din_byte,
   input  logic       din_valid,
   input  logic       syn_in,
   output logic       dout_bit,
   output logic       dout_valid,
   output logic       syn_out,
   output logic       err_overrun
);

   localparam int BW    = (BRANCHES > 1) ? $clog2(BRANCHES) : 1;
   localparam int MAXD  = UNIT_DEPTH * (BRANCHES - 1);
   localparam int PW    = (MAXD > 1) ? $clog2(MAXD) : 1;
   localparam int TOTAL = (UNIT_DEPTH * BRANCHES * (BRANCHES - 1)) / 2;
   localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int MW    = (TOTAL > 0) ? TOTAL * 8 : 8;

   // First storage slot of branch j. Branches are packed back to back.
   function automatic int base_of(input int j);
      return (UNIT_DEPTH * (j - 1) * j) / 2;
   endfunction

   // FIFO depth of branch j, in bytes.
   function automatic int depth_of(input int j);
      return j * UNIT_DEPTH;
   endfunction

   logic [BW-1:0]          br_q, br_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [7:0]             sh_q, sh_d;
   logic [BRANCHES*PW-1:0] ptr_q, ptr_d;
   logic                   syn_q, syn_d;
   logic                   err_q, err_d;
   logic [MW-1:0]          mem_q;

   logic                   accept;
   logic                   drop;
   logic [BW-1:0]          sel;
   int                     sel_i;
   logic                   is_fifo;
   logic [PW-1:0]          ptr_cur;
   logic [PW-1:0]          ptr_nxt;
   logic [AW-1:0]          addr;
   logic [7:0]             fifo_out;
   logic [7:0]             ilv_byte;

   // Stage p0: accept decision, branch select and FIFO lookup for the incoming byte
   always_comb begin
      // The serializer takes a new byte when it is idle or showing its last bit.
      accept   = din_valid && ((cnt_q == 4'd0) || (cnt_q == 4'd8));
      drop     = din_valid && !accept;
      // A sync byte always goes on branch 0, whatever the commutator position.
      sel      = syn_in ? '0 : br_q;
      sel_i    = int'(sel);
      is_fifo  = (sel != '0);
      ptr_cur  = ptr_q[sel_i*PW +: PW];
      ptr_nxt  = (ptr_cur == PW'(depth_of(sel_i) - 1)) ? '0 : ptr_cur + 1'b1;
      addr     = AW'(base_of(sel_i)) + AW'(ptr_cur);
      fifo_out = mem_q[int'(addr)*8 +: 8];
      ilv_byte = is_fifo ? fifo_out : din_byte;
   end

   // Next state for the commutator, pointers and output shifter
   always_comb begin
      br_d  = br_q;
      cnt_d = cnt_q;
      sh_d  = sh_q;
      ptr_d = ptr_q;
      syn_d = accept && syn_in;
      err_d = drop;
      if (accept) begin
         br_d  = (sel == BW'(BRANCHES - 1)) ? '0 : sel + 1'b1;
         cnt_d = 4'd1;
         sh_d  = ilv_byte;
         if (is_fifo) begin
            ptr_d[sel_i*PW +: PW] = ptr_nxt;
         end
      end else if (cnt_q != 4'd0) begin
         // Zero-fill means the shifter is empty once the last bit has gone out.
         sh_d  = {sh_q[6:0], 1'b0};
         cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
      end
   end

   // Stage p1: control and serializer registers; reset aborts any byte in flight
   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) begin
         br_q  <= '0;
         cnt_q <= '0;
         sh_q  <= '0;
         ptr_q <= '0;
         syn_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         br_q  <= br_d;
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
         ptr_q <= ptr_d;
         syn_q <= syn_d;
         err_q <= err_d;
      end
   end

   // Branch FIFO storage: push the new byte where the oldest one was just read
   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else if (accept && is_fifo) begin
         mem_q[int'(addr)*8 +: 8] <= din_byte;
      end
   end

   assign dout_bit    = sh_q[7];
   assign dout_valid  = (cnt_q != 4'd0);
   assign syn_out     = syn_q;
   assign err_overrun = err_q;

endmodule

// File: doc/conv_interleave_tx.md
CONV_INTERLEAVE_TX -- requirements
Module: conv_interleave_tx

Interface
REQ-001 SHALL have parameter BRANCHES, default 12, meaning the number of commutator branches.
REQ-002 SHALL have parameter UNIT_DEPTH, default 17, meaning the byte delay increment per branch.
REQ-003 SHALL have port clk_bit, input, 1 bit: bit clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port din_byte, input, 8 bits: byte to interleave, sampled when din_valid=1.
REQ-006 SHALL have port din_valid, input, 1 bit: single-cycle strobe marking one input byte.
REQ-007 SHALL have port syn_in, input, 1 bit: qualified by din_valid; marks the packet sync byte.
REQ-008 SHALL have port dout_bit, output, 1 bit: serial interleaved data, MSB first.
REQ-009 SHALL have port dout_valid, output, 1 bit: high while dout_bit carries a valid bit.
REQ-010 SHALL have port syn_out, output, 1 bit: high during the MSB of an output sync byte only.
REQ-011 SHALL have port err_overrun, output, 1 bit: one-cycle pulse on a dropped input byte.

Function
REQ-012 SHALL hold a branch counter br in 0..BRANCHES-1, advancing by 1 per accepted byte and wrapping from BRANCHES-1 to 0.
REQ-013 SHALL force br to 0 for any accepted byte with syn_in=1, and then advance to 1 for the next byte.
REQ-014 SHALL route each accepted byte to branch br: branch 0 passes with no delay; branch j (j>=1) is a FIFO of j*UNIT_DEPTH bytes.
REQ-015 SHALL, on each accepted byte for branch j>=1, push the byte into FIFO j and emit its oldest entry, which equals the byte accepted on the j*UNIT_DEPTH-th previous visit to branch j.
REQ-016 SHALL give, for a continuous stream, a delay of j*UNIT_DEPTH*BRANCHES byte slots on branch j (204*j at defaults).
REQ-017 SHALL accept din_valid at cycle t when the serializer is idle or at its 8th bit (cycle t0+8 after the previous accept at t0).
REQ-018 SHALL, for din_valid at t0+1..t0+7, drop the byte, leave br and all FIFOs unchanged, and pulse err_overrun at t+1.
REQ-019 SHALL, for a byte accepted at t, load the interleaved byte into the output shifter and drive its MSB on dout_bit at t+1 and its LSB at t+8.
REQ-020 SHALL hold dout_valid=1 for cycles t+1..t+8; accepts every 8 cycles SHALL give gap-free dout_valid.
REQ-021 SHALL hold dout_valid=0 and dout_bit=0 when no byte is being shifted.
REQ-022 SHALL assert syn_out at t+1 for exactly one cycle when the byte accepted at t had syn_in=1.
REQ-023 SHALL ignore syn_in when din_valid=0.
REQ-024 SHALL output 0x00 from FIFO positions not yet written since reset.

Reset
REQ-025 SHALL, while rst_n=0, clear br to 0, all FIFO contents to 0x00, and the shifter and bit counter to 0, and drive dout_bit=0, dout_valid=0, syn_out=0, err_overrun=0.
REQ-026 SHALL, on rst_n assertion mid-byte, abort serialization immediately; the first din_valid after release SHALL be accepted unconditionally.

Verification
REQ-027 SHALL be covered: reset, then byte 0x47 with syn_in=1 -> dout_bit 0,1,0,0,0,1,1,1 over cycles t+1..t+8; syn_out=1 only at t+1; dout_valid=1 for those 8 cycles.
REQ-028 SHALL be covered: continuous stream every 8 cycles, byte n = n mod 256, sync on n=0 -> output slot 1 = 0x00 and output slot 205 = 0x01; output slot 12*k = 12*k mod 256.
REQ-029 SHALL be covered: full-depth stream of 2500 bytes -> output slot s = input slot s - 204*(s mod 12) for all s >= 2244; compare against a software model.
REQ-030 SHALL be covered: din_valid 3 cycles after an accept -> err_overrun=1 for 1 cycle, that byte is absent from the output, and br is unchanged.
REQ-031 SHALL be covered: syn_in=1 on a byte arriving when br=5 -> the byte goes on branch 0 (zero delay, syn_out=1) and the next byte goes on branch 1.
REQ-032 SHALL be covered: rst_n pulsed low at bit 4 of a byte -> dout_valid=0 and dout_bit=0 at once; after release, FIFO outputs read 0x00 and a sync byte re-aligns the stream.
